// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I control unit (FETCH/DECODE/EXEC/MEM/WB, sticky HALT).
// Define CONTROL_FSM_INSTRET_EN to build the 32-bit retired-instruction counter.
module control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  output logic [2:0]  instruction_type,
  output logic [3:0]  reg_file_wr,
  output logic [3:0]  alu_op,
  output logic        alu_sel_1,
  output logic        alu_sel_2,
  output logic [3:0]  mem_wr,
  output logic        wb_sel,
  output logic [2:0]  branch,
  output logic        pc_en,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_HALT   = 3'b111
  } state_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  function automatic logic is_legal(input logic [6:0] opc, input logic [2:0] f3);
    case (opc)
      OPC_R, OPC_IALU, OPC_LUI, OPC_AUIPC: is_legal = 1'b1;
      OPC_LOAD:   is_legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OPC_STORE:  is_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      OPC_BRANCH: is_legal = (f3 != 3'b010) && (f3 != 3'b011);
      default:    is_legal = 1'b0;
    endcase
  endfunction

  // funct7[5] selects SUB only for register-register ops, SRA for both shift forms
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'b000:  alu_from_f3 = (is_r && alt) ? 4'b0001 : 4'b0000;
      3'b001:  alu_from_f3 = 4'b0010;
      3'b010:  alu_from_f3 = 4'b0011;
      3'b011:  alu_from_f3 = 4'b0100;
      3'b100:  alu_from_f3 = 4'b0101;
      3'b101:  alu_from_f3 = alt ? 4'b0111 : 4'b0110;
      3'b110:  alu_from_f3 = 4'b1000;
      default: alu_from_f3 = 4'b1001;
    endcase
  endfunction

  logic [6:0] opc_s;
  logic [2:0] f3_s;
  logic       f7b5_s;
  logic       unused_ir_s;
  assign opc_s       = ir_q[6:0];
  assign f3_s        = ir_q[14:12];
  assign f7b5_s      = ir_q[30];
  assign unused_ir_s = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  logic [2:0] dec_type_s, dec_branch_s;
  logic [3:0] dec_alu_s, dec_rfwr_s, dec_memwr_s;
  logic       dec_sel1_s, dec_sel2_s, dec_wbsel_s;
  logic       dec_load_s, dec_store_s, dec_br_s;

  // Decode the latched instruction register
  always_comb begin
    dec_type_s   = 3'b000;
    dec_alu_s    = 4'b0000;
    dec_sel1_s   = 1'b0;
    dec_sel2_s   = 1'b0;
    dec_wbsel_s  = 1'b0;
    dec_branch_s = 3'd0;
    dec_rfwr_s   = 4'b0000;
    dec_memwr_s  = 4'b0000;
    dec_load_s   = 1'b0;
    dec_store_s  = 1'b0;
    dec_br_s     = 1'b0;
    case (opc_s)
      OPC_R: begin
        dec_type_s  = 3'b101;
        dec_alu_s   = alu_from_f3(f3_s, f7b5_s, 1'b1);
        dec_rfwr_s  = 4'b0101;
        dec_wbsel_s = 1'b1;
      end
      OPC_IALU: begin
        dec_alu_s   = alu_from_f3(f3_s, f7b5_s, 1'b0);
        dec_sel2_s  = 1'b1;
        dec_rfwr_s  = 4'b0101;
        dec_wbsel_s = 1'b1;
      end
      OPC_LOAD: begin
        dec_sel2_s = 1'b1;
        dec_load_s = 1'b1;
        case (f3_s)
          3'b000:  dec_rfwr_s = 4'b0001;
          3'b001:  dec_rfwr_s = 4'b0011;
          3'b010:  dec_rfwr_s = 4'b0101;
          3'b100:  dec_rfwr_s = 4'b1001;
          3'b101:  dec_rfwr_s = 4'b1011;
          default: dec_rfwr_s = 4'b0000;
        endcase
      end
      OPC_STORE: begin
        dec_type_s  = 3'b001;
        dec_sel2_s  = 1'b1;
        dec_store_s = 1'b1;
        case (f3_s)
          3'b000:  dec_memwr_s = 4'b0001;
          3'b001:  dec_memwr_s = 4'b0011;
          3'b010:  dec_memwr_s = 4'b1111;
          default: dec_memwr_s = 4'b0000;
        endcase
      end
      OPC_BRANCH: begin
        dec_type_s = 3'b010;
        dec_alu_s  = 4'b0001;
        dec_br_s   = 1'b1;
        case (f3_s)
          3'b000:  dec_branch_s = 3'd1;
          3'b001:  dec_branch_s = 3'd2;
          3'b100:  dec_branch_s = 3'd3;
          3'b101:  dec_branch_s = 3'd5;
          3'b110:  dec_branch_s = 3'd4;
          3'b111:  dec_branch_s = 3'd6;
          default: dec_branch_s = 3'd0;
        endcase
      end
      OPC_LUI: begin
        dec_type_s  = 3'b011;
        dec_alu_s   = 4'b1010;
        dec_sel2_s  = 1'b1;
        dec_rfwr_s  = 4'b0101;
        dec_wbsel_s = 1'b1;
      end
      OPC_AUIPC: begin
        dec_type_s  = 3'b011;
        dec_sel1_s  = 1'b1;
        dec_sel2_s  = 1'b1;
        dec_rfwr_s  = 4'b0101;
        dec_wbsel_s = 1'b1;
      end
      default: begin
        dec_type_s = 3'b000;
      end
    endcase
  end

  // Next state, IR capture and strobes
  always_comb begin
    state_d          = state_q;
    ir_d             = ir_q;
    illegal_d        = illegal_q;
    instruction_type = 3'b000;
    alu_op           = 4'b0000;
    alu_sel_1        = 1'b0;
    alu_sel_2        = 1'b0;
    wb_sel           = 1'b0;
    branch           = 3'd0;
    reg_file_wr      = 4'b0000;
    mem_wr           = 4'b0000;
    pc_en            = 1'b0;
    if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
      instruction_type = dec_type_s;
      alu_op           = dec_alu_s;
      alu_sel_1        = dec_sel1_s;
      alu_sel_2        = dec_sel2_s;
      wb_sel           = dec_wbsel_s;
      branch           = dec_branch_s;
    end else begin
      instruction_type = 3'b000;
    end
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = instruction;
        if (is_legal(instruction[6:0], instruction[14:12])) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (dec_br_s) begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else if (dec_load_s || dec_store_s) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_wr = dec_memwr_s;
        if (!mem_ready) begin
          state_d = S_MEM;
        end else if (dec_store_s) begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_file_wr = dec_rfwr_s;
        pc_en       = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State, IR and sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

`ifdef CONTROL_FSM_INSTRET_EN
  logic [31:0] instret_q, instret_d;
  assign instret_d = pc_en ? (instret_q + 32'd1) : instret_q;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= 32'd0;
    end else begin
      instret_q <= instret_d;
    end
  end
  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: table-driven self-checking bench for control_fsm,
// plus hand-written sequences for HALT, mid-MEM reset and instret wrap.
`timescale 1ns/1ps
module tb_control_fsm;

  logic        clk, reset, mem_ready;
  logic [31:0] instruction;
  logic [2:0]  instruction_type, branch, state;
  logic [3:0]  reg_file_wr, alu_op, mem_wr;
  logic        alu_sel_1, alu_sel_2, wb_sel, pc_en, illegal;
  logic [31:0] instret;

  localparam logic [2:0] ST_FETCH  = 3'b000;
  localparam logic [2:0] ST_DECODE = 3'b001;
  localparam logic [2:0] ST_EXEC   = 3'b010;
  localparam logic [2:0] ST_MEM    = 3'b011;
  localparam logic [2:0] ST_WB     = 3'b100;
  localparam logic [2:0] ST_HALT   = 3'b111;

  control_fsm dut (
    .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
    .instruction_type(instruction_type), .reg_file_wr(reg_file_wr), .alu_op(alu_op),
    .alu_sel_1(alu_sel_1), .alu_sel_2(alu_sel_2), .mem_wr(mem_wr), .wb_sel(wb_sel),
    .branch(branch), .pc_en(pc_en), .state(state), .illegal(illegal), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          stalls;
    logic [2:0]  typ;
    logic [3:0]  alu;
    logic        sel1;
    logic        sel2;
    logic [2:0]  br;
    logic [3:0]  rfwr;
    logic [3:0]  memwr;
    logic        wbsel;
    int          cycles;
  } vec_t;

  vec_t        vecs[12];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_instret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic mr);
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = mr;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    mem_ready   = 1'b0;
    exp_instret = 32'd0;
    check("rst_state", 32'(state), 32'(ST_FETCH));
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_strobes", 32'({pc_en, reg_file_wr, mem_wr}), 32'd0);
    check("rst_decoded", 32'({instruction_type, alu_op, alu_sel_1, alu_sel_2, wb_sel, branch}), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc    = 0;
    int memcnt = 0;
    bit done   = 1'b0;
    instruction = v.instr;
    while (!done && cyc < 40) begin
      @(negedge clk);
      mem_ready = (state == ST_MEM) && (memcnt >= v.stalls);
      #1;
      if (cyc == 0) begin
        check($sformatf("v%0d_start_state", idx), 32'(state), 32'(ST_FETCH));
        check($sformatf("v%0d_instret", idx), instret, exp_instret);
      end
      case (state)
        ST_FETCH, ST_DECODE:
          check($sformatf("v%0d_fd_decoded_zero", idx),
                32'({instruction_type, alu_op, alu_sel_1, alu_sel_2, wb_sel, branch}), 32'd0);
        ST_EXEC: begin
          check($sformatf("v%0d_exec_type", idx), 32'(instruction_type), 32'(v.typ));
          check($sformatf("v%0d_exec_alu", idx), 32'(alu_op), 32'(v.alu));
          check($sformatf("v%0d_exec_sel", idx), 32'({alu_sel_1, alu_sel_2}), 32'({v.sel1, v.sel2}));
          check($sformatf("v%0d_exec_branch", idx), 32'(branch), 32'(v.br));
          check($sformatf("v%0d_exec_pc_en", idx), 32'(pc_en), 32'(v.br != 3'd0));
        end
        ST_MEM: begin
          check($sformatf("v%0d_mem_wr", idx), 32'(mem_wr), 32'(v.memwr));
          memcnt++;
        end
        ST_WB: begin
          check($sformatf("v%0d_wb_rfwr", idx), 32'(reg_file_wr), 32'(v.rfwr));
          check($sformatf("v%0d_wb_sel", idx), 32'(wb_sel), 32'(v.wbsel));
        end
        default: check($sformatf("v%0d_unexpected_state", idx), 32'(state), 32'(ST_FETCH));
      endcase
      if (state != ST_MEM) check($sformatf("v%0d_memwr_idle", idx), 32'(mem_wr), 32'd0);
      if (state != ST_WB)  check($sformatf("v%0d_rfwr_idle", idx), 32'(reg_file_wr), 32'd0);
      cyc++;
      if (pc_en) done = 1'b1;
    end
    check($sformatf("v%0d_cycles", idx), 32'(cyc), 32'(v.cycles));
`ifdef CONTROL_FSM_INSTRET_EN
    exp_instret = exp_instret + 32'd1;
`endif
  endtask

  task automatic run_illegal(input logic [31:0] ins, input int halt_cycles, input string tag);
    do_reset(1'b0);
    instruction = ins;
    @(negedge clk); #1;
    check({tag, "_fetch"}, 32'(state), 32'(ST_FETCH));
    @(negedge clk); #1;
    check({tag, "_decode"}, 32'(state), 32'(ST_DECODE));
    for (int i = 0; i < halt_cycles; i++) begin
      @(negedge clk); #1;
      check({tag, "_halt_state"}, 32'(state), 32'(ST_HALT));
      check({tag, "_illegal"}, 32'(illegal), 32'd1);
      check({tag, "_strobes"}, 32'({pc_en, reg_file_wr, mem_wr}), 32'd0);
    end
    do_reset(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          instr         stl typ     alu      s1    s2    br    rfwr     memwr    wb    cyc
    vecs[0]  = '{32'h002081B3, 0, 3'b101, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0101, 4'b0000, 1'b1, 4}; // add
    vecs[1]  = '{32'h402081B3, 0, 3'b101, 4'b0001, 1'b0, 1'b0, 3'd0, 4'b0101, 4'b0000, 1'b1, 4}; // sub
    vecs[2]  = '{32'h003130B3, 0, 3'b101, 4'b0100, 1'b0, 1'b0, 3'd0, 4'b0101, 4'b0000, 1'b1, 4}; // sltu
    vecs[3]  = '{32'h40315093, 0, 3'b000, 4'b0111, 1'b0, 1'b1, 3'd0, 4'b0101, 4'b0000, 1'b1, 4}; // srai
    vecs[4]  = '{32'h0002CF03, 2, 3'b000, 4'b0000, 1'b0, 1'b1, 3'd0, 4'b1001, 4'b0000, 1'b0, 7}; // lbu, 2 stalls
    vecs[5]  = '{32'h00029003, 0, 3'b000, 4'b0000, 1'b0, 1'b1, 3'd0, 4'b0011, 4'b0000, 1'b0, 5}; // lh x0
    vecs[6]  = '{32'h0062A023, 0, 3'b001, 4'b0000, 1'b0, 1'b1, 3'd0, 4'b0000, 4'b1111, 1'b0, 4}; // sw
    vecs[7]  = '{32'h00628023, 1, 3'b001, 4'b0000, 1'b0, 1'b1, 3'd0, 4'b0000, 4'b0001, 1'b0, 5}; // sb, 1 stall
    vecs[8]  = '{32'h7E000663, 0, 3'b010, 4'b0001, 1'b0, 1'b0, 3'd1, 4'b0000, 4'b0000, 1'b0, 3}; // beq
    vecs[9]  = '{32'h00007063, 0, 3'b010, 4'b0001, 1'b0, 1'b0, 3'd6, 4'b0000, 4'b0000, 1'b0, 3}; // bgeu
    vecs[10] = '{32'h123450B7, 0, 3'b011, 4'b1010, 1'b0, 1'b1, 3'd0, 4'b0101, 4'b0000, 1'b1, 4}; // lui
    vecs[11] = '{32'h00000097, 0, 3'b011, 4'b0000, 1'b1, 1'b1, 3'd0, 4'b0101, 4'b0000, 1'b1, 4}; // auipc

    reset       = 1'b1;
    mem_ready   = 1'b0;
    instruction = 32'd0;
    exp_instret = 32'd0;
    repeat (2) @(posedge clk);
    do_reset(1'b0);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], i);
    end
    @(negedge clk); #1;
    check("final_instret", instret, exp_instret);

    run_illegal(32'hFFFFFFFF, 20, "ill_ffff");
    run_illegal(32'h00003003, 3, "ill_load");
    run_illegal(32'h00002063, 3, "ill_branch");

    // Reset during a MEM stall, with mem_ready raised in the reset cycle
    begin
      int memseen = 0;
      do_reset(1'b0);
      instruction = 32'h0002CF03;
      for (int i = 0; i < 10 && memseen < 3; i++) begin
        @(negedge clk); #1;
        if (state == ST_MEM) memseen++;
      end
      check("midmem_reached", 32'(memseen), 32'd3);
      check("midmem_no_wr", 32'({pc_en, reg_file_wr}), 32'd0);
      do_reset(1'b1);
      run_vec(vecs[0], 100);
    end

`ifdef CONTROL_FSM_INSTRET_EN
    do_reset(1'b0);
    instruction = 32'h002081B3;
    @(negedge clk);
    force dut.instret_q = 32'hFFFFFFFF;
    #1;
    release dut.instret_q;
    check("wrap_preload", instret, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    @(negedge clk); #1;
    check("wrap_state", 32'(state), 32'(ST_FETCH));
    check("wrap_instret", instret, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
- REQ-001 The module SHALL have no parameters; all encodings are fixed as defined below.
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 reset  input  1  synchronous, active-high reset.
- REQ-004 instruction  input  32  instruction word from instruction memory, valid during DECODE.
- REQ-005 mem_ready  input  1  data memory done; sampled only in MEM.
- REQ-006 instruction_type  output  3  I=000, S=001, B=010, U=011, J=100, R=101 (immediate-generator select).
- REQ-007 reg_file_wr  output  4  NO=0000, B=0001, H=0011, W=0101, BU=1001, HU=1011.
- REQ-008 alu_op  output  4  ADD=0000, SUB=0001, SLL=0010, SLT=0011, SLTU=0100, XOR=0101, SRL=0110, SRA=0111, OR=1000, AND=1001, PASSB=1010.
- REQ-009 alu_sel_1  output  1  0=rs1, 1=PC.
- REQ-010 alu_sel_2  output  1  0=rs2, 1=immediate.
- REQ-011 mem_wr  output  4  byte write mask: SB=0001, SH=0011, SW=1111, none=0000.
- REQ-012 wb_sel  output  1  1=ALU result, 0=memory read data.
- REQ-013 branch  output  3  NO=0, EQ=1, NE=2, LT=3, LTU=4, GE=5, GEU=6.
- REQ-014 pc_en  output  1  one-cycle PC update strobe (retire).
- REQ-015 state  output  3  FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, HALT=111.
- REQ-016 illegal  output  1  sticky illegal-instruction flag.
- REQ-017 instret  output  32  retired-instruction count (see Configuration).

Function
- REQ-018 The FSM SHALL sequence FETCH->DECODE->EXEC, then per class: ALU/LUI/AUIPC EXEC->WB->FETCH (4 cycles); load EXEC->MEM->WB->FETCH (5+); store EXEC->MEM->FETCH (4+); branch EXEC->FETCH (3).
- REQ-019 MEM SHALL hold while mem_ready=0 and exit on the first cycle with mem_ready=1.
- REQ-020 An internal 32-bit IR SHALL load instruction on the edge leaving DECODE; all decoded outputs derive from IR and hold from EXEC until the next DECODE exit.
- REQ-021 Decoded outputs (instruction_type, alu_op, alu_sel_1/2, wb_sel, branch) SHALL be 0 during FETCH and DECODE.
- REQ-022 Opcodes: 0110011 R; 0010011 I-ALU; 0000011 load (I); 0100011 store (S); 1100011 branch (B); 0110111 LUI (U, PASSB, alu_sel_2=1); 0010111 AUIPC (U, ADD, alu_sel_1=1, alu_sel_2=1); any other opcode illegal.
- REQ-023 ALU funct3: 000 ADD (SUB if R and funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7[5]), 110 OR, 111 AND.
- REQ-024 Load funct3 000/001/010/100/101 SHALL map to reg_file_wr B/H/W/BU/HU; other funct3 illegal; loads and stores use ADD, alu_sel_2=1.
- REQ-025 Store funct3 000/001/010 SHALL map to mem_wr 0001/0011/1111; other illegal.
- REQ-026 Branch funct3 000/001/100/101/110/111 SHALL map to EQ/NE/LT/GE/LTU/GEU with alu_op=SUB, alu_sel_2=0; 010/011 illegal.
- REQ-027 reg_file_wr SHALL be non-zero only in WB; mem_wr non-zero only in MEM, every MEM cycle of a store including stall cycles.
- REQ-028 wb_sel SHALL be 0 for loads, 1 for all other register-writing classes.
- REQ-029 pc_en SHALL pulse exactly once per instruction: in WB, in the final (mem_ready=1) MEM cycle of a store, or in EXEC for a branch.
- REQ-030 An illegal instruction SHALL cause DECODE->HALT, set illegal=1, and issue no pc_en, reg_file_wr or mem_wr; HALT persists until reset.
- REQ-031 A write to rd=x0 SHALL still assert reg_file_wr; the register file ignores x0.

Reset
- REQ-032 reset=1 at a clock edge SHALL force state=FETCH, IR=0, illegal=0, instret=0, and all strobes/decoded outputs 0 on the next cycle, from any state including mid-MEM stall and HALT.
- REQ-033 reset SHALL take priority over all transitions and mem_ready.

Configuration
- REQ-034 Macro CONTROL_FSM_INSTRET_EN SHALL, when defined, implement a 32-bit instret counter that increments on each pc_en cycle and wraps 0xFFFFFFFF->0.
- REQ-035 Without CONTROL_FSM_INSTRET_EN, instret SHALL be constant 0 and no counter flops exist.

Verification
- REQ-036 add x3,x1,x2 (0x002081B3) -> EXEC: alu_op=0000, sel 0/0, type R; WB: reg_file_wr=0101, wb_sel=1, pc_en=1; 4 cycles total.
- REQ-037 lbu x30,0(x5) (0x0002CF03) with mem_ready low 2 cycles -> MEM held 3 cycles, WB reg_file_wr=1001, wb_sel=0; 7 cycles total.
- REQ-038 sw x6,0(x5) (0x0062A023), mem_ready=1 -> MEM mem_wr=1111, pc_en=1 same cycle, no WB.
- REQ-039 beq x0,x0,+2028 (0x7E000663) -> EXEC: branch=1, alu_op=0001, type B, pc_en=1; 3 cycles.
- REQ-040 0xFFFFFFFF -> HALT, illegal=1, no strobes for 20 cycles; reset -> FETCH, illegal=0.
- REQ-041 With CONTROL_FSM_INSTRET_EN, instret forced to 0xFFFFFFFF plus one retire -> 0; without macro instret stays 0.
